// File: rtl/lr_pkg.sv
// Shared definitions for the local-RAM arbiter: default address width,
// clear sequencer states and fixed timing constants.
package lr_pkg;

    localparam int AW_DEFAULT   = 12;
    localparam int DRAIN_CYCLES = 2;
    localparam int READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } clr_state_t;

endpackage

// File: rtl/lr_rr_arb.sv
// Round-robin arbiter with its own rotating pointer. The winner index is
// reported even when mask_en suppresses the grant, so the parent can compare
// the would-be winner against other traffic before committing to a grant.
module lr_rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 mask_en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] win_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          win_found;

    // Search upward from the pointer with wrap for the first asserted request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign gnt = (win_found && !mask_en) ? (N'(1) << win_idx) : '0;

    // Move the pointer just past the granted requester; hold it otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (win_found && !mask_en) begin
            ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/lr_arbiter.sv
// Local-RAM arbiter: independent round-robin read and write ports in front
// of a 32-bit RAM with registered read, plus a sequencer that zero-fills the
// whole RAM on command.
module lr_arbiter
    import lr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = AW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    rd_req,
    input  logic [NUM_REQ*AW-1:0] rd_addr,
    output logic [NUM_REQ-1:0]    rd_gnt,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic [31:0]           rd_data,
    input  logic [NUM_REQ-1:0]    wr_req,
    input  logic [NUM_REQ*AW-1:0] wr_addr,
    input  logic [NUM_REQ*32-1:0] wr_data,
    input  logic [NUM_REQ*4-1:0]  wr_be,
    output logic [NUM_REQ-1:0]    wr_gnt,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [AW-1:0]         ram_raddr,
    output logic [AW-1:0]         ram_waddr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    clr_state_t    state;
    clr_state_t    state_next;
    logic [1:0]    drain_cnt;
    logic [AW-1:0] clr_cnt;
    logic          busy;

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          rd_mask;
    logic          wr_mask;
    logic          collision;
    logic [AW-1:0] rd_sel_addr;
    logic [AW-1:0] wr_sel_addr;
    logic [31:0]   wr_sel_data;
    logic [3:0]    wr_sel_be;

    logic          pipe_v1;
    logic          pipe_v2;
    logic [IW-1:0] pipe_idx1;
    logic [IW-1:0] pipe_idx2;

    assign busy     = (state != IDLE);
    assign clr_busy = busy;
    assign clr_done = (state == DONE);

    assign collision = (|rd_req) && (|wr_req) && (rd_sel_addr == wr_sel_addr);
    assign wr_mask   = reset || busy;
    assign rd_mask   = reset || busy || collision;

    lr_rr_arb #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (rd_req),
        .mask_en (rd_mask),
        .gnt     (rd_gnt),
        .win_idx (rd_idx)
    );

    lr_rr_arb #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wr_req),
        .mask_en (wr_mask),
        .gnt     (wr_gnt),
        .win_idx (wr_idx)
    );

    // Pick out the address, data and byte enables of each channel's winner.
    always_comb begin
        rd_sel_addr = '0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        wr_sel_be   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_sel_addr = rd_addr[i*AW +: AW];
            end
            if (wr_idx == IW'(i)) begin
                wr_sel_addr = wr_addr[i*AW +: AW];
                wr_sel_data = wr_data[i*32 +: 32];
                wr_sel_be   = wr_be[i*4 +: 4];
            end
        end
    end

    // Clear sequencer next-state: drain in-flight reads, sweep every word, pulse done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_start) state_next = DRAIN;
            DRAIN:   if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_next = CLEAR;
            CLEAR:   if (&clr_cnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer state and its drain/sweep counters; the sweep counter wraps back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            clr_cnt   <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            clr_cnt   <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    // Register the read address and track which requester owns each read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_raddr <= '0;
            pipe_v1   <= 1'b0;
            pipe_v2   <= 1'b0;
            pipe_idx1 <= '0;
            pipe_idx2 <= '0;
        end else begin
            pipe_v1   <= |rd_gnt;
            pipe_idx1 <= rd_idx;
            pipe_v2   <= pipe_v1;
            pipe_idx2 <= pipe_idx1;
            if (|rd_gnt) begin
                ram_raddr <= rd_sel_addr;
            end
        end
    end

    assign rd_valid = pipe_v2 ? (NUM_REQ'(1) << pipe_idx2) : '0;
    assign rd_data  = ram_rdata;

    // Register the RAM write port from either the sweep or the granted requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_we    <= '0;
        end else if (state == CLEAR) begin
            ram_waddr <= clr_cnt;
            ram_wdata <= '0;
            ram_we    <= 4'hF;
        end else if (|wr_gnt) begin
            ram_waddr <= wr_sel_addr;
            ram_wdata <= wr_sel_data;
            ram_we    <= wr_sel_be;
        end else begin
            ram_we    <= '0;
        end
    end

endmodule

// File: doc/lr_arbiter.md
Name: lr_arbiter

Overview:
Shares one 16 KB local RAM among NUM_REQ requesters. The RAM is 32-bit wide, with separate read and write word addresses, per-byte write enables and 1-cycle registered read. The block runs two independent round-robin arbiters, one for the read port and one for the write port, and registers the RAM-side signals. It also contains a clear sequencer that zero-fills the whole RAM on command. It sits between the per-core lookup engines and the local RAM instance in each multicore cluster.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AW, 12, RAM word-address width (4096 words x 32 bit)

Ports:
clk  in  1  clock; one clock domain
reset  in  1  synchronous, active-high reset
rd_req  in  NUM_REQ  per-requester read request; held until rd_gnt
rd_addr  in  NUM_REQ*AW  packed word addresses; requester i at [i*AW +: AW]
rd_gnt  out  NUM_REQ  one-hot, combinational, at most one bit per cycle
rd_valid  out  NUM_REQ  one-hot pulse; rd_data valid for that requester
rd_data  out  32  shared read data
wr_req  in  NUM_REQ  per-requester write request; held until wr_gnt
wr_addr  in  NUM_REQ*AW  packed word addresses
wr_data  in  NUM_REQ*32  packed write data
wr_be  in  NUM_REQ*4  packed byte enables; bit0 = data[7:0]
wr_gnt  out  NUM_REQ  one-hot, combinational
clr_start  in  1  pulse; starts a full clear
clr_busy  out  1  high while a clear is in progress
clr_done  out  1  1-cycle pulse when a clear completes
ram_raddr  out  AW  to RAM raddr[13:2], registered
ram_waddr  out  AW  to RAM waddr[13:2], registered
ram_wdata  out  32  to RAM data_in, registered
ram_we  out  4  to RAM we[3:0], registered
ram_rdata  in  32  from RAM data_out

Behaviour:
- Reset values (synchronous, applied at the clk edge while reset=1):
  - rd_gnt=0, wr_gnt=0, rd_valid=0, ram_we=0, ram_raddr=0, ram_waddr=0, ram_wdata=0.
  - clr_busy=0, clr_done=0; both round-robin pointers=0; FSM=IDLE; clear counter=0.
- Handshake:
  - A request is consumed in the cycle its gnt bit is 1.
  - The requester may drop the request or present a new one in the next cycle.
  - Address and data must stay stable while the request is pending.
  - Grants are never given to an unasserted request.
- Round-robin (each channel has its own pointer):
  - Search starts at the pointer index and ascends with wrap.
  - On a grant to index k, the pointer becomes (k+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Read timing:
  - Grant in cycle T; ram_raddr is registered at the end of T.
  - The RAM samples at the end of T+1.
  - In cycle T+2, rd_valid[k]=1 and rd_data=ram_rdata.
  - Fixed latency of 2 cycles; throughput 1 read per cycle.
  - A 2-stage valid/index pipeline tracks the owner of each read.
- Write timing:
  - Grant in T; ram_waddr, ram_wdata and ram_we=wr_be[k] are registered at the end of T.
  - The RAM commits at the end of T+1.
  - ram_we=0 in any cycle following a cycle with no write grant.
- Collision:
  - If the read winner's address equals the write winner's address in the same cycle, the read grant is suppressed and only the write is granted.
  - The read pointer does not advance; the read is re-arbitrated next cycle and returns the new data.
  - A read granted in T+1 after a write granted in T needs no extra handling.
- Clear FSM: IDLE, DRAIN, CLEAR, DONE.
  - IDLE: clr_start=1 moves to DRAIN.
  - DRAIN: lasts exactly 2 cycles; no grants; in-flight reads still return.
  - CLEAR: one write per cycle, ram_waddr=counter, ram_wdata=0, ram_we=4'hF, counter 0 to 2^AW-1; no grants. After the write of address 2^AW-1 is issued, move to DONE.
  - DONE: clr_done=1 for 1 cycle, then IDLE; the counter returns to 0.
- clr_busy=1 in DRAIN, CLEAR and DONE; clr_start is ignored while busy.
- Reset during a clear aborts it with no clr_done; RAM contents are left partially cleared.
- Reset also flushes the read-return pipeline, so no rd_valid appears for reads in flight.

Decomposition:
- Shared package lr_pkg: AW default, the FSM state enum (IDLE/DRAIN/CLEAR/DONE), the DRAIN_CYCLES=2 constant and the READ_LATENCY=2 constant.
- One sub-module, lr_rr_arb: parameter N; inputs req[N] and mask_en; outputs gnt[N] (one-hot) and the winner index; holds its own pointer. It is instantiated twice.

Test Plan:
- Read latency: rd_req[2]=1, rd_addr=12'h010 in cycle 0 (RAM holding 32'hDEADBEEF at 0x010) -> rd_gnt[2] in cycle 0, ram_raddr=0x010 in cycle 1, rd_valid[2]=1 and rd_data=32'hDEADBEEF in cycle 2.
- Fairness: all four rd_req held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rd_valid follows the same order 2 cycles later.
- Byte write: wr_be=4'b0101, wr_data=32'h11223344 to 0x020 (initially 32'hAAAAAAAA), then read 0x020 -> 32'hAA22AA44.
- Collision: in the same cycle, wr 0x030 <- 32'h5 and rd 0x030 -> only wr_gnt in that cycle; rd_gnt the next cycle; rd_data=32'h5.
- Clear: clr_start with all requests held -> 2 DRAIN cycles, then 4096 writes of zero, clr_done pulse in cycle 4099 relative to start (cycle 0), no grants meanwhile; then read 0xFFF -> 0.
- Reset mid-clear: reset asserted at counter=100 -> clr_busy=0 next cycle, clr_done never pulses, grants resume, address 0x200 retains its prior contents.
